dpll_lock_ctrl: RTL and testbench

Acquisition and lock sequencer for the DPLL loop. Measures phase-detector error per reference period, sequences loop-filter clear, fast acquisition and slow tracking, and reports lock/unlock. Sits between the synchronized phase-detector outputs and the loop filter/NCO control inputs.

---
 rtl/dpll_pkg.sv | 28 ++
 rtl/dpll_err_meter.sv | 55 +++++
 rtl/dpll_lock_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dpll_lock_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL acquisition/lock sequencer: state encodings,
// counter type and default loop parameters.
package dpll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_TRACK   = 3'd3,
    ST_HOLD    = 3'd4
  } dpll_state_e;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int CLR_CYCLES_DEF = 8;
  localparam int ERR_W_DEF      = 8;
  localparam int WINDOW_DEF     = 4;
  localparam int LOCK_N_DEF     = 16;
  localparam int UNLOCK_N_DEF   = 4;
  localparam int TIMEOUT_N_DEF  = 1024;
  localparam int HOLD_N_DEF     = 8;

  function automatic cnt_t cnt_inc(input cnt_t c);
    return c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/dpll_err_meter.sv
// Saturating per-reference-period phase error meter; emits a registered
// period_valid/period_good pair for each ref_tick it is allowed to judge.
module dpll_err_meter #(
  parameter int ERR_W  = dpll_pkg::ERR_W_DEF,
  parameter int WINDOW = dpll_pkg::WINDOW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic ref_tick,
  input  logic pd_lead,
  input  logic pd_lag,
  output logic period_valid,
  output logic period_good
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [ERR_W-1:0] err_cnt_q, err_cnt_d, err_sum;
  logic             valid_q, valid_d, good_q, good_d;

  always_comb begin
    // Lead and lag in the same cycle are one error cycle, not two.
    err_sum = err_cnt_q;
    if ((pd_lead | pd_lag) && (err_cnt_q != ERR_MAX)) begin
      err_sum = err_cnt_q + ERR_W'(1);
    end
    err_cnt_d = err_sum;
    valid_d   = 1'b0;
    good_d    = 1'b0;
    if (clr) begin
      err_cnt_d = '0;
    end else if (ref_tick) begin
      valid_d   = 1'b1;
      good_d    = (int'(err_sum) <= WINDOW);
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
      valid_q   <= 1'b0;
      good_q    <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      valid_q   <= valid_d;
      good_q    <= good_d;
    end
  end

  assign period_valid = valid_q;
  assign period_good  = good_q;

endmodule

// File: rtl/dpll_lock_ctrl.sv
// DPLL acquisition/lock sequencer: IDLE -> CLEAR -> ACQUIRE -> TRACK.
// Optional holdover after unlock is enabled by defining DPLL_HOLDOVER_EN.
module dpll_lock_ctrl #(
  parameter int CLR_CYCLES = dpll_pkg::CLR_CYCLES_DEF,
  parameter int ERR_W      = dpll_pkg::ERR_W_DEF,
  parameter int WINDOW     = dpll_pkg::WINDOW_DEF,
  parameter int LOCK_N     = dpll_pkg::LOCK_N_DEF,
  parameter int UNLOCK_N   = dpll_pkg::UNLOCK_N_DEF,
`ifdef DPLL_HOLDOVER_EN
  parameter int HOLD_N     = dpll_pkg::HOLD_N_DEF,
`endif
  parameter int TIMEOUT_N  = dpll_pkg::TIMEOUT_N_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ref_tick,
  input  logic       pd_lead,
  input  logic       pd_lag,
  output logic       loop_en,
  output logic       filt_clr,
  output logic       gain_sel,
  output logic       locked,
  output logic       lock_lost,
  output logic       acq_timeout,
  output logic [2:0] state
);
  import dpll_pkg::*;

  dpll_state_e state_q, state_d;
  cnt_t        good_cnt_q, good_cnt_d;
  cnt_t        bad_cnt_q, bad_cnt_d;
  cnt_t        period_cnt_q, period_cnt_d;
  cnt_t        clr_cnt_q, clr_cnt_d;
`ifdef DPLL_HOLDOVER_EN
  cnt_t        hold_cnt_q, hold_cnt_d;
`endif
  logic        loop_en_q, loop_en_d;
  logic        filt_clr_q, filt_clr_d;
  logic        gain_sel_q, gain_sel_d;
  logic        locked_q, locked_d;
  logic        lock_lost_q, lock_lost_d;
  logic        acq_timeout_q, acq_timeout_d;
  logic        meter_clr, period_valid, period_good;

  // Any ref_tick seen while idle or clearing is discarded by the meter.
  assign meter_clr = (state_q == ST_IDLE) || (state_q == ST_CLEAR);

  dpll_err_meter #(
    .ERR_W  (ERR_W),
    .WINDOW (WINDOW)
  ) u_err_meter (
    .clk          (clk),
    .reset        (reset),
    .clr          (meter_clr),
    .ref_tick     (ref_tick),
    .pd_lead      (pd_lead),
    .pd_lag       (pd_lag),
    .period_valid (period_valid),
    .period_good  (period_good)
  );

  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    period_cnt_d  = period_cnt_q;
    clr_cnt_d     = clr_cnt_q;
`ifdef DPLL_HOLDOVER_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    lock_lost_d   = 1'b0;
    acq_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == cnt_t'(CLR_CYCLES - 1)) begin
          state_d      = ST_ACQUIRE;
          good_cnt_d   = '0;
          period_cnt_d = '0;
        end else begin
          clr_cnt_d = cnt_inc(clr_cnt_q);
        end
      end
      ST_ACQUIRE: begin
        if (period_valid) begin
          period_cnt_d = cnt_inc(period_cnt_q);
          good_cnt_d   = period_good ? cnt_inc(good_cnt_q) : '0;
          // Reaching lock on the very period that would time out wins.
          if (period_good && (cnt_inc(good_cnt_q) == cnt_t'(LOCK_N))) begin
            state_d      = ST_TRACK;
            good_cnt_d   = '0;
            bad_cnt_d    = '0;
            period_cnt_d = '0;
          end else if (cnt_inc(period_cnt_q) == cnt_t'(TIMEOUT_N)) begin
            state_d       = ST_CLEAR;
            clr_cnt_d     = '0;
            good_cnt_d    = '0;
            period_cnt_d  = '0;
            acq_timeout_d = 1'b1;
          end
        end
      end
      ST_TRACK: begin
        if (period_valid) begin
          if (period_good) begin
            bad_cnt_d = '0;
          end else if (cnt_inc(bad_cnt_q) == cnt_t'(UNLOCK_N)) begin
            lock_lost_d  = 1'b1;
            good_cnt_d   = '0;
            bad_cnt_d    = '0;
            period_cnt_d = '0;
`ifdef DPLL_HOLDOVER_EN
            state_d      = ST_HOLD;
            hold_cnt_d   = '0;
`else
            state_d      = ST_ACQUIRE;
`endif
          end else begin
            bad_cnt_d = cnt_inc(bad_cnt_q);
          end
        end
      end
`ifdef DPLL_HOLDOVER_EN
      ST_HOLD: begin
        // Re-acquire from the held integrator value, no filter clear.
        if (period_valid) begin
          if (cnt_inc(hold_cnt_q) == cnt_t'(HOLD_N)) begin
            state_d      = ST_ACQUIRE;
            hold_cnt_d   = '0;
            good_cnt_d   = '0;
            period_cnt_d = '0;
          end else begin
            hold_cnt_d = cnt_inc(hold_cnt_q);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (!start) begin
      state_d       = ST_IDLE;
      good_cnt_d    = '0;
      bad_cnt_d     = '0;
      period_cnt_d  = '0;
      clr_cnt_d     = '0;
`ifdef DPLL_HOLDOVER_EN
      hold_cnt_d    = '0;
`endif
      lock_lost_d   = 1'b0;
      acq_timeout_d = 1'b0;
    end

    loop_en_d  = (state_d == ST_ACQUIRE) || (state_d == ST_TRACK);
    filt_clr_d = (state_d == ST_CLEAR);
    gain_sel_d = (state_d == ST_ACQUIRE);
    locked_d   = (state_d == ST_TRACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      period_cnt_q  <= '0;
      clr_cnt_q     <= '0;
`ifdef DPLL_HOLDOVER_EN
      hold_cnt_q    <= '0;
`endif
      loop_en_q     <= 1'b0;
      filt_clr_q    <= 1'b0;
      gain_sel_q    <= 1'b0;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
      acq_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      period_cnt_q  <= period_cnt_d;
      clr_cnt_q     <= clr_cnt_d;
`ifdef DPLL_HOLDOVER_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
      loop_en_q     <= loop_en_d;
      filt_clr_q    <= filt_clr_d;
      gain_sel_q    <= gain_sel_d;
      locked_q      <= locked_d;
      lock_lost_q   <= lock_lost_d;
      acq_timeout_q <= acq_timeout_d;
    end
  end

  assign loop_en     = loop_en_q;
  assign filt_clr    = filt_clr_q;
  assign gain_sel    = gain_sel_q;
  assign locked      = locked_q;
  assign lock_lost   = lock_lost_q;
  assign acq_timeout = acq_timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Directed self-checking bench for dpll_lock_ctrl (default parameters).
// Holdover-specific steps are compiled in when DPLL_HOLDOVER_EN is defined.
module tb_dpll_lock_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, ref_tick, pd_lead, pd_lag;
  logic       loop_en, filt_clr, gain_sel, locked, lock_lost, acq_timeout;
  logic [2:0] state;
  int         tests = 0;
  int         fails = 0;
  int         n;

  always #5 clk = ~clk;

  dpll_lock_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ref_tick    (ref_tick),
    .pd_lead     (pd_lead),
    .pd_lag      (pd_lag),
    .loop_en     (loop_en),
    .filt_clr    (filt_clr),
    .gain_sel    (gain_sel),
    .locked      (locked),
    .lock_lost   (lock_lost),
    .acq_timeout (acq_timeout),
    .state       (state)
  );

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_outs"},
          32'({loop_en, filt_clr, gain_sel, locked, lock_lost, acq_timeout}), 32'd0);
  endtask

  // One reference period of len cycles; pd active in the first errc cycles,
  // ref_tick on the last cycle.
  task automatic period(input int len, input int errc, input bit lead, input bit lag);
    for (int i = 0; i < len; i++) begin
      ref_tick = (i == len - 1);
      pd_lead  = lead && (i < errc);
      pd_lag   = lag && (i < errc);
      step(1);
    end
    ref_tick = 1'b0;
    pd_lead  = 1'b0;
    pd_lag   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ref_tick = 1'b0; pd_lead = 1'b0; pd_lag = 1'b0;
    step(2);
    check_idle("reset");
    $display("[TB] reset held: state=%0d", state);
    reset = 1'b1;
    step(1);
    check_idle("idle_nostart");

    // Start: exactly 8 cycles of filter clear, then ACQUIRE
    start = 1'b1;
    step(1);
    check("clear_state", 32'(state), 32'd1);
    check("clear_loop_en", 32'(loop_en), 32'd0);
    n = 0;
    while (filt_clr === 1'b1 && n < 50) begin
      n++;
      step(1);
    end
    check("clr_len", 32'(n), 32'd8);
    check("acq_state", 32'(state), 32'd2);
    check("acq_gain", 32'({loop_en, gain_sel, locked}), 32'b110);
    $display("[TB] clear lasted %0d cycles, state=%0d", n, state);

    // 16 clean periods -> locked one cycle after the 16th ref_tick
    for (int p = 0; p < 16; p++) period(20, 0, 1'b0, 1'b0);
    check("pre_lock", 32'(locked), 32'd0);
    step(1);
    check("lock", 32'(locked), 32'd1);
    check("track_state", 32'(state), 32'd3);
    check("track_outs", 32'({loop_en, gain_sel}), 32'b10);
    $display("[TB] lock after 16 periods: locked=%0d state=%0d", locked, state);

    // 3 bad, then one period with lead+lag together 4 cycles (good: counts 4)
    for (int p = 0; p < 3; p++) period(20, 5, 1'b1, 1'b0);
    period(20, 4, 1'b1, 1'b1);
    for (int p = 0; p < 3; p++) period(20, 5, 1'b1, 1'b0);
    step(1);
    check("both_high_good", 32'(state), 32'd3);
    $display("[TB] lead+lag overlap period: state=%0d", state);

    // 4th consecutive bad period -> unlock
    period(20, 5, 1'b1, 1'b0);
    check("pre_unlock", 32'({locked, lock_lost}), 32'b10);
    step(1);
    check("lock_lost_pulse", 32'(lock_lost), 32'd1);
    check("unlock_locked", 32'(locked), 32'd0);
`ifdef DPLL_HOLDOVER_EN
    check("unlock_state", 32'(state), 32'd4);
    check("hold_outs", 32'({loop_en, gain_sel, filt_clr}), 32'd0);
    step(1);
    check("lock_lost_end", 32'(lock_lost), 32'd0);
    start = 1'b0;
    step(1);
    check_idle("stop_hold");
    $display("[TB] start dropped in HOLD: state=%0d", state);
    start = 1'b1;
    step(9);
    check("restart_acq", 32'(state), 32'd2);
`else
    check("unlock_state", 32'(state), 32'd2);
    check("unlock_gain", 32'(gain_sel), 32'd1);
    step(1);
    check("lock_lost_end", 32'(lock_lost), 32'd0);
`endif
    $display("[TB] unlock: state=%0d gain_sel=%0d", state, gain_sel);

    // Saturation: 260 error cycles would wrap to 4 (good); saturated 255 is bad
    for (int p = 0; p < 15; p++) period(20, 0, 1'b0, 1'b0);
    period(260, 260, 1'b0, 1'b1);
    step(1);
    check("sat_bad", 32'(state), 32'd2);
    period(20, 0, 1'b0, 1'b0);
    step(1);
    check("sat_no_lock", 32'({state, locked}), 32'({3'd2, 1'b0}));
    $display("[TB] saturation period judged bad: state=%0d", state);

    // start dropped mid-ACQUIRE
    start = 1'b0;
    step(1);
    check_idle("stop_acq");
    $display("[TB] start dropped in ACQUIRE: state=%0d", state);
    start = 1'b1;
    step(9);
    check("reacq_state", 32'(state), 32'd2);

    // Continuous lead: every period bad -> timeout after 1024 periods
    for (int p = 0; p < 1024; p++) period(8, 8, 1'b1, 1'b0);
    check("pre_timeout", 32'({state, acq_timeout}), 32'({3'd2, 1'b0}));
    step(1);
    check("timeout_pulse", 32'(acq_timeout), 32'd1);
    check("timeout_state", 32'({state, filt_clr}), 32'({3'd1, 1'b1}));
    step(1);
    check("timeout_end", 32'(acq_timeout), 32'd0);
    $display("[TB] acquire timeout: state=%0d filt_clr=%0d", state, filt_clr);

    // Asynchronous reset mid-CLEAR: outputs drop without a clock edge
    #2;
    reset = 1'b0;
    #1;
    check_idle("async_reset");
    $display("[TB] async reset: state=%0d", state);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
